// File: rtl/hex7_pkg.sv
// Shared definitions for the 7-segment display capture block: segment
// patterns for the hex digits, grid classification and capture FSM states.
package hex7_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    GRID_BLANK  = 2'd0,
    GRID_SELECT = 2'd1,
    GRID_MULTI  = 2'd2
  } grid_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } cap_state_e;

  typedef struct packed {
    grid_kind_e  kind;
    logic [1:0]  idx;
  } grid_cls_t;

  // Classify the active-low grid: one low bit selects a digit, none is blank,
  // anything else is an illegal multi-select.
  function automatic grid_cls_t classify_grid(input logic [3:0] grid_n);
    grid_cls_t cls;
    cls.kind = GRID_MULTI;
    cls.idx  = 2'd0;
    case (grid_n)
      4'b1111: cls.kind = GRID_BLANK;
      4'b1110: begin cls.kind = GRID_SELECT; cls.idx = 2'd0; end
      4'b1101: begin cls.kind = GRID_SELECT; cls.idx = 2'd1; end
      4'b1011: begin cls.kind = GRID_SELECT; cls.idx = 2'd2; end
      4'b0111: begin cls.kind = GRID_SELECT; cls.idx = 2'd3; end
      default: cls.kind = GRID_MULTI;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational segment-pattern to nibble decoder; flags patterns that are
// not one of the sixteen hex glyphs.
module hex7_decode
  import hex7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       valid_o
);

  // Reverse lookup of the glyph table
  always_comb begin
    nib_o   = 4'h0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_0:   nib_o = 4'h0;
      SEG_1:   nib_o = 4'h1;
      SEG_2:   nib_o = 4'h2;
      SEG_3:   nib_o = 4'h3;
      SEG_4:   nib_o = 4'h4;
      SEG_5:   nib_o = 4'h5;
      SEG_6:   nib_o = 4'h6;
      SEG_7:   nib_o = 4'h7;
      SEG_8:   nib_o = 4'h8;
      SEG_9:   nib_o = 4'h9;
      SEG_A:   nib_o = 4'hA;
      SEG_B:   nib_o = 4'hB;
      SEG_C:   nib_o = 4'hC;
      SEG_D:   nib_o = 4'hD;
      SEG_E:   nib_o = 4'hE;
      SEG_F:   nib_o = 4'hF;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/hex_display_capture.sv
// Reader for a multiplexed 4-digit 7-segment display. Waits for each digit
// select to settle, decodes the glyph, assembles a 16-bit frame and tracks
// how many consecutive frames were identical.
module hex_display_capture
  import hex7_pkg::*;
#(
  parameter int SETTLE_CYC    = 4,
  parameter int STABLE_FRAMES = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  hex_seg,
  input  logic [3:0]  hex_grid,
  input  logic        clr_err,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        stable,
  output logic        seg_err,
  output logic        grid_err
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYC);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [SW-1:0] STB_ONE    = SW'(1);

  // Capture FSM registers
  cap_state_e    state_q;
  logic [1:0]    sel_q;
  logic [7:0]    pat_q;
  logic [CW-1:0] cnt_q;

  // Frame assembly and output registers
  logic [NUM_DIGITS-1:0][3:0] slot_q, slot_d;
  logic [NUM_DIGITS-1:0]      slot_dp_q, slot_dp_d;
  logic [NUM_DIGITS-1:0]      seen_q, seen_d;
  logic [15:0]                value_q, value_d;
  logic [3:0]                 dp_q, dp_d;
  logic                       fv_q, fv_d;
  logic [SW-1:0]              stab_q, stab_d;
  logic                       seg_err_q, seg_err_d;
  logic                       grid_err_q, grid_err_d;

  grid_cls_t     cls;
  logic          is_sel, new_visit, reload, cont, cap_fire;
  logic [CW-1:0] cnt_next;
  logic [3:0]    dec_nib;
  logic          dec_valid;
  logic          frame_done;
  logic          frame_match;

  hex7_decode u_dec (
    .seg_i   (~hex_seg[6:0]),
    .nib_o   (dec_nib),
    .valid_o (dec_valid)
  );

  // Settle tracking: decide whether this cycle starts, restarts or extends a
  // settle run, and whether the run has just reached the capture threshold.
  always_comb begin
    cls       = classify_grid(hex_grid);
    is_sel    = (cls.kind == GRID_SELECT);
    new_visit = is_sel && ((state_q == ST_IDLE) || (cls.idx != sel_q));
    reload    = is_sel && (state_q == ST_SETTLE) && (cls.idx == sel_q) && (hex_seg != pat_q);
    cont      = is_sel && (state_q == ST_SETTLE) && (cls.idx == sel_q) && (hex_seg == pat_q);
    cnt_next  = (new_visit || reload) ? CNT_ONE : cnt_q + CNT_ONE;
    cap_fire  = (new_visit || reload || cont) && (cnt_next == SETTLE_MAX);
  end

  // Capture FSM: HOLD blocks recapture of the same digit until the select moves
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      pat_q   <= 8'h00;
      cnt_q   <= '0;
    end else if (!is_sel) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (new_visit || reload || cont) begin
      sel_q   <= cls.idx;
      pat_q   <= hex_seg;
      cnt_q   <= cnt_next;
      state_q <= cap_fire ? ST_HOLD : ST_SETTLE;
    end
  end

  // Slot writes, frame publish and stability counting
  always_comb begin
    frame_done  = (seen_q == 4'hF);
    slot_d      = slot_q;
    slot_dp_d   = slot_dp_q;
    // A completed frame clears seen so a same-cycle capture starts the next one
    seen_d      = frame_done ? 4'h0 : seen_q;
    if (cap_fire && dec_valid) begin
      slot_d[cls.idx]    = dec_nib;
      slot_dp_d[cls.idx] = ~hex_seg[7];
      seen_d[cls.idx]    = 1'b1;
    end

    value_d     = value_q;
    dp_d        = dp_q;
    stab_d      = stab_q;
    fv_d        = frame_done;
    // A zero count means no earlier frame since reset, so nothing to match
    frame_match = (stab_q != '0) && (slot_q == value_q) && (slot_dp_q == dp_q);
    if (frame_done) begin
      value_d = slot_q;
      dp_d    = slot_dp_q;
      if (frame_match)
        stab_d = (stab_q == STABLE_MAX) ? STABLE_MAX : stab_q + STB_ONE;
      else
        stab_d = STB_ONE;
    end

    // An error event in the same cycle as clr_err wins
    seg_err_d  = (seg_err_q  & ~clr_err) | (cap_fire & ~dec_valid);
    grid_err_d = (grid_err_q & ~clr_err) | (cls.kind == GRID_MULTI);
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      slot_q     <= '0;
      slot_dp_q  <= '0;
      seen_q     <= '0;
      value_q    <= '0;
      dp_q       <= '0;
      fv_q       <= 1'b0;
      stab_q     <= '0;
      seg_err_q  <= 1'b0;
      grid_err_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      slot_dp_q  <= slot_dp_d;
      seen_q     <= seen_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      fv_q       <= fv_d;
      stab_q     <= stab_d;
      seg_err_q  <= seg_err_d;
      grid_err_q <= grid_err_d;
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign frame_valid = fv_q;
  assign stable      = (stab_q == STABLE_MAX);
  assign seg_err     = seg_err_q;
  assign grid_err    = grid_err_q;

endmodule
